// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control path: opcodes, ALUOp codes,
// mux selects, state encodings and the internal control-word layout.
package mips_multicycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_SLT   = 2'b11;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG_A  = 2'b11;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_FETCH     = 4'd1;
  localparam logic [3:0] ST_DECODE    = 4'd2;
  localparam logic [3:0] ST_MEM_ADDR  = 4'd3;
  localparam logic [3:0] ST_MEM_READ  = 4'd4;
  localparam logic [3:0] ST_MEM_WB    = 4'd5;
  localparam logic [3:0] ST_MEM_WRITE = 4'd6;
  localparam logic [3:0] ST_R_EXEC    = 4'd7;
  localparam logic [3:0] ST_R_WB      = 4'd8;
  localparam logic [3:0] ST_IMM_EXEC  = 4'd9;
  localparam logic [3:0] ST_IMM_WB    = 4'd10;
  localparam logic [3:0] ST_BRANCH    = 4'd11;
  localparam logic [3:0] ST_JUMP      = 4'd12;
  localparam logic [3:0] ST_JR        = 4'd13;
  localparam logic [3:0] ST_TRAP      = 4'd14;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_word_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control/datapath bundle: IR fields and status in, strobes and mux selects out.
// master = control FSM side, slave = datapath side.
interface mips_multicycle_ctrl_if #(
  parameter int OPC_W   = 6,
  parameter int STATE_W = 4
);
  logic [OPC_W-1:0]   opcode;
  logic [OPC_W-1:0]   funct;
  logic               zero;
  logic               mem_ready;
  logic               pc_en;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               MemtoReg;
  logic               RegDst;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic               ALUOp1;
  logic               ALUOp2;
  logic [1:0]         PCSource;
  logic               instr_done;
  logic               illegal;
  logic [STATE_W-1:0] state_dbg;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_en, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp1, ALUOp2, PCSource, instr_done, illegal, state_dbg
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_en, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp1, ALUOp2, PCSource, instr_done, illegal, state_dbg
  );
endinterface

// File: rtl/mips_multicycle_ctrl_dispatch.sv
// DECODE dispatch: maps (opcode, funct) to the state that follows DECODE.
// Anything not recognised lands in TRAP.
module mips_ctrl_dispatch
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int OPC_W   = 6,
  parameter int STATE_W = 4
) (
  input  logic [OPC_W-1:0]   opcode,
  input  logic [OPC_W-1:0]   funct,
  output logic [STATE_W-1:0] next_state
);

  always_comb begin
    next_state = ST_TRAP;
    case (opcode)
      OP_RTYPE: next_state = (funct == FN_JR) ? ST_JR : ST_R_EXEC;
      OP_LW,
      OP_SW:    next_state = ST_MEM_ADDR;
      OP_BEQ:   next_state = ST_BRANCH;
      OP_J:     next_state = ST_JUMP;
      OP_SLTI:  next_state = ST_IMM_EXEC;
      default:  next_state = ST_TRAP;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS-32 core: state register, transition
// logic and per-state control-word decode; memory steps stall on mem_ready.
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int OPC_W   = 6,
  parameter int STATE_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  mips_multicycle_ctrl_if.master bus
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] next_state;
  logic [STATE_W-1:0] decode_next;
  logic               illegal_q;
  ctrl_word_t         cw;

  mips_ctrl_dispatch #(
    .OPC_W  (OPC_W),
    .STATE_W(STATE_W)
  ) u_dispatch (
    .opcode    (bus.opcode),
    .funct     (bus.funct),
    .next_state(decode_next)
  );

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      next_state = ST_FETCH;
      ST_FETCH:     next_state = bus.mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE:    next_state = decode_next;
      ST_MEM_ADDR:  next_state = (bus.opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ:  next_state = bus.mem_ready ? ST_MEM_WB : ST_MEM_READ;
      ST_MEM_WRITE: next_state = bus.mem_ready ? ST_FETCH : ST_MEM_WRITE;
      ST_R_EXEC:    next_state = ST_R_WB;
      ST_IMM_EXEC:  next_state = ST_IMM_WB;
      ST_MEM_WB,
      ST_R_WB,
      ST_IMM_WB,
      ST_BRANCH,
      ST_JUMP,
      ST_JR:        next_state = ST_FETCH;
      ST_TRAP:      next_state = ST_TRAP;
      default:      next_state = ST_IDLE;
    endcase
  end

  // illegal rises together with the entry into TRAP so both are visible in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state     <= next_state;
      illegal_q <= illegal_q | (next_state == ST_TRAP);
    end
  end

  always_comb begin
    cw = '0;
    case (state)
      ST_FETCH: begin
        cw.mem_read  = 1'b1;
        cw.alu_src_b = SRCB_FOUR;
        cw.alu_op    = ALUOP_ADD;
        cw.pc_source = PCSRC_ALU;
        cw.ir_write  = bus.mem_ready;
        cw.pc_write  = bus.mem_ready;
      end
      ST_DECODE: begin
        cw.alu_src_b = SRCB_IMM_SH;
        cw.alu_op    = ALUOP_ADD;
      end
      ST_MEM_ADDR: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = ALUOP_ADD;
      end
      ST_MEM_READ: begin
        cw.mem_read = 1'b1;
        cw.iord     = 1'b1;
      end
      ST_MEM_WB: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = 1'b1;
        cw.instr_done = 1'b1;
      end
      ST_MEM_WRITE: begin
        cw.mem_write  = 1'b1;
        cw.iord       = 1'b1;
        cw.instr_done = bus.mem_ready;
      end
      ST_R_EXEC: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_REG;
        cw.alu_op    = ALUOP_FUNCT;
      end
      ST_R_WB: begin
        cw.reg_write  = 1'b1;
        cw.reg_dst    = 1'b1;
        cw.instr_done = 1'b1;
      end
      ST_IMM_EXEC: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = ALUOP_SLT;
      end
      ST_IMM_WB: begin
        cw.reg_write  = 1'b1;
        cw.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        cw.alu_src_a     = 1'b1;
        cw.alu_src_b     = SRCB_REG;
        cw.alu_op        = ALUOP_SUB;
        cw.pc_write_cond = 1'b1;
        cw.pc_source     = PCSRC_ALUOUT;
        cw.instr_done    = 1'b1;
      end
      ST_JUMP: begin
        cw.pc_write   = 1'b1;
        cw.pc_source  = PCSRC_JUMP;
        cw.instr_done = 1'b1;
      end
      ST_JR: begin
        cw.pc_write   = 1'b1;
        cw.pc_source  = PCSRC_REG_A;
        cw.instr_done = 1'b1;
      end
      default: cw = '0;
    endcase
  end

  assign bus.pc_en      = cw.pc_write | (cw.pc_write_cond & bus.zero);
  assign bus.IorD       = cw.iord;
  assign bus.MemRead    = cw.mem_read;
  assign bus.MemWrite   = cw.mem_write;
  assign bus.IRWrite    = cw.ir_write;
  assign bus.MemtoReg   = cw.mem_to_reg;
  assign bus.RegDst     = cw.reg_dst;
  assign bus.RegWrite   = cw.reg_write;
  assign bus.ALUSrcA    = cw.alu_src_a;
  assign bus.ALUSrcB    = cw.alu_src_b;
  assign bus.ALUOp1     = cw.alu_op[1];
  assign bus.ALUOp2     = cw.alu_op[0];
  assign bus.PCSource   = cw.pc_source;
  assign bus.instr_done = cw.instr_done;
  assign bus.illegal    = illegal_q;
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: table of instructions with fixed
// latencies, an opcode sweep, a random instruction stream and reset/trap sequences.
module tb_mips_multicycle_ctrl;
  import mips_multicycle_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mips_multicycle_ctrl_if #(.OPC_W(6), .STATE_W(4)) bus ();

  mips_multicycle_ctrl #(.OPC_W(6), .STATE_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef enum int {
    K_IDLE, K_FETCH, K_DECODE, K_MEM_ADDR, K_MEM_READ, K_MEM_WB, K_MEM_WRITE,
    K_R_EXEC, K_R_WB, K_IMM_EXEC, K_IMM_WB, K_BRANCH, K_JUMP, K_JR, K_TRAP
  } step_e;

  typedef struct packed {
    logic       pc_en;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] alu_op;
    logic [1:0] PCSource;
    logic       instr_done;
    logic       illegal;
    logic [3:0] state;
  } obs_t;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    bit          z;
    int unsigned fst;
    int unsigned mst;
    int unsigned cycles;
  } vec_t;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          ill_m = 1'b0;
  int unsigned cyc;
  int unsigned done_at;

  function automatic logic [3:0] st_code(step_e s);
    case (s)
      K_IDLE:      return ST_IDLE;
      K_FETCH:     return ST_FETCH;
      K_DECODE:    return ST_DECODE;
      K_MEM_ADDR:  return ST_MEM_ADDR;
      K_MEM_READ:  return ST_MEM_READ;
      K_MEM_WB:    return ST_MEM_WB;
      K_MEM_WRITE: return ST_MEM_WRITE;
      K_R_EXEC:    return ST_R_EXEC;
      K_R_WB:      return ST_R_WB;
      K_IMM_EXEC:  return ST_IMM_EXEC;
      K_IMM_WB:    return ST_IMM_WB;
      K_BRANCH:    return ST_BRANCH;
      K_JUMP:      return ST_JUMP;
      K_JR:        return ST_JR;
      default:     return ST_TRAP;
    endcase
  endfunction

  // Expected outputs of each step, written straight from the step descriptions
  function automatic obs_t model_out(step_e s, bit mr, bit z, bit ill);
    obs_t o;
    o = '0;
    o.illegal = ill;
    o.state   = st_code(s);
    case (s)
      K_FETCH:     begin o.MemRead = 1; o.ALUSrcB = 2'b01; o.IRWrite = mr; o.pc_en = mr; end
      K_DECODE:    o.ALUSrcB = 2'b11;
      K_MEM_ADDR:  begin o.ALUSrcA = 1; o.ALUSrcB = 2'b10; end
      K_MEM_READ:  begin o.MemRead = 1; o.IorD = 1; end
      K_MEM_WB:    begin o.RegWrite = 1; o.MemtoReg = 1; o.instr_done = 1; end
      K_MEM_WRITE: begin o.MemWrite = 1; o.IorD = 1; o.instr_done = mr; end
      K_R_EXEC:    begin o.ALUSrcA = 1; o.alu_op = 2'b10; end
      K_R_WB:      begin o.RegWrite = 1; o.RegDst = 1; o.instr_done = 1; end
      K_IMM_EXEC:  begin o.ALUSrcA = 1; o.ALUSrcB = 2'b10; o.alu_op = 2'b11; end
      K_IMM_WB:    begin o.RegWrite = 1; o.instr_done = 1; end
      K_BRANCH:    begin o.ALUSrcA = 1; o.alu_op = 2'b01; o.PCSource = 2'b01;
                         o.pc_en = z; o.instr_done = 1; end
      K_JUMP:      begin o.pc_en = 1; o.PCSource = 2'b10; o.instr_done = 1; end
      K_JR:        begin o.pc_en = 1; o.PCSource = 2'b11; o.instr_done = 1; end
      default:     ;
    endcase
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.pc_en      = bus.pc_en;
    o.IorD       = bus.IorD;
    o.MemRead    = bus.MemRead;
    o.MemWrite   = bus.MemWrite;
    o.IRWrite    = bus.IRWrite;
    o.MemtoReg   = bus.MemtoReg;
    o.RegDst     = bus.RegDst;
    o.RegWrite   = bus.RegWrite;
    o.ALUSrcA    = bus.ALUSrcA;
    o.ALUSrcB    = bus.ALUSrcB;
    o.alu_op     = {bus.ALUOp1, bus.ALUOp2};
    o.PCSource   = bus.PCSource;
    o.instr_done = bus.instr_done;
    o.illegal    = bus.illegal;
    o.state      = bus.state_dbg;
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t exp);
    obs_t act;
    act = sample();
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at posedge+1; drives one cycle, checks at negedge, returns at next posedge+1
  task automatic run_step(input step_e s, input bit mr, input bit z,
                          input logic [5:0] op, input logic [5:0] fn);
    bus.mem_ready = mr;
    bus.zero      = z;
    bus.opcode    = op;
    bus.funct     = fn;
    if (s == K_TRAP) ill_m = 1'b1;
    @(negedge clk);
    cyc++;
    check_obs(s.name(), model_out(s, mr, z, ill_m));
    if (bus.instr_done === 1'b1 && done_at == 0) done_at = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int unsigned n);
    rst_n         = 1'b0;
    bus.mem_ready = 1'b1;
    bus.zero      = 1'b1;
    bus.opcode    = 6'h3F;
    bus.funct     = 6'h00;
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      ill_m = 1'b0;
      check_obs("reset_idle", model_out(K_IDLE, 1'b1, 1'b1, 1'b0));
    end
    rst_n = 1'b1;
    #1;
    check_obs("idle_after_release", model_out(K_IDLE, 1'b1, 1'b1, 1'b0));
    @(posedge clk);
    #1;
  endtask

  // Builds the step list of one instruction from the opcode rules, then runs it
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                           input int unsigned fst, input int unsigned mst,
                           input int unsigned hold,
                           output int unsigned done_cycle, output int unsigned model_len);
    step_e q[$];
    bit    m[$];
    bit    trap;
    logic [5:0] opx, fnx;
    bit zz;
    trap = 1'b0;
    for (int unsigned i = 0; i < fst; i++) begin q.push_back(K_FETCH); m.push_back(1'b0); end
    q.push_back(K_FETCH);  m.push_back(1'b1);
    q.push_back(K_DECODE); m.push_back(1'($urandom_range(0, 1)));
    if (op == 6'b000000 && fn == 6'b001000) begin
      q.push_back(K_JR); m.push_back(1'($urandom_range(0, 1)));
    end else if (op == 6'b000000) begin
      q.push_back(K_R_EXEC); m.push_back(1'($urandom_range(0, 1)));
      q.push_back(K_R_WB);   m.push_back(1'($urandom_range(0, 1)));
    end else if (op == 6'b100011 || op == 6'b101011) begin
      q.push_back(K_MEM_ADDR); m.push_back(1'($urandom_range(0, 1)));
      for (int unsigned i = 0; i <= mst; i++) begin
        q.push_back(op == 6'b100011 ? K_MEM_READ : K_MEM_WRITE);
        m.push_back(i == mst);
      end
      if (op == 6'b100011) begin q.push_back(K_MEM_WB); m.push_back(1'($urandom_range(0, 1))); end
    end else if (op == 6'b000100) begin
      q.push_back(K_BRANCH); m.push_back(1'($urandom_range(0, 1)));
    end else if (op == 6'b000010) begin
      q.push_back(K_JUMP); m.push_back(1'($urandom_range(0, 1)));
    end else if (op == 6'b001010) begin
      q.push_back(K_IMM_EXEC); m.push_back(1'($urandom_range(0, 1)));
      q.push_back(K_IMM_WB);   m.push_back(1'($urandom_range(0, 1)));
    end else begin
      trap = 1'b1;
      for (int unsigned i = 0; i < hold; i++) begin
        q.push_back(K_TRAP); m.push_back(1'($urandom_range(0, 1)));
      end
    end
    cyc     = 0;
    done_at = 0;
    foreach (q[i]) begin
      opx = (q[i] == K_FETCH) ? 6'($urandom) : op;
      fnx = (q[i] == K_FETCH) ? 6'($urandom) : fn;
      zz  = (q[i] == K_BRANCH) ? z : 1'($urandom_range(0, 1));
      run_step(q[i], m[i], zz, opx, fnx);
    end
    done_cycle = done_at;
    model_len  = trap ? 0 : q.size();
    if (trap) do_reset(2);
  endtask

  vec_t        tbl[13];
  int unsigned dc, ml;
  logic [5:0]  rop, rfn;
  logic [5:0]  legal_ops[6];

  initial begin
    tbl[0]  = '{6'h00, 6'h20, 1'b0, 0, 0, 4};  // add
    tbl[1]  = '{6'h23, 6'h00, 1'b0, 0, 3, 8};  // lw, 3 stall cycles
    tbl[2]  = '{6'h23, 6'h11, 1'b0, 0, 0, 5};  // lw
    tbl[3]  = '{6'h2B, 6'h00, 1'b0, 0, 2, 6};  // sw, 2 stalls
    tbl[4]  = '{6'h2B, 6'h05, 1'b1, 0, 0, 4};  // sw
    tbl[5]  = '{6'h04, 6'h00, 1'b1, 0, 0, 3};  // beq taken
    tbl[6]  = '{6'h04, 6'h00, 1'b0, 0, 0, 3};  // beq not taken
    tbl[7]  = '{6'h02, 6'h00, 1'b0, 0, 0, 3};  // j
    tbl[8]  = '{6'h00, 6'h08, 1'b0, 0, 0, 3};  // jr
    tbl[9]  = '{6'h0A, 6'h00, 1'b0, 0, 0, 4};  // slti
    tbl[10] = '{6'h00, 6'h22, 1'b0, 2, 0, 6};  // sub, fetch stalls
    tbl[11] = '{6'h04, 6'h00, 1'b1, 1, 0, 4};  // beq with fetch stall
    tbl[12] = '{6'h3F, 6'h00, 1'b0, 0, 0, 0};  // illegal: never completes
    legal_ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h0A};

    bus.mem_ready = 1'b0;
    bus.zero      = 1'b0;
    bus.opcode    = 6'h00;
    bus.funct     = 6'h00;
    do_reset(2);

    foreach (tbl[i]) begin
      run_instr(tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].fst, tbl[i].mst, 20, dc, ml);
      check_int($sformatf("latency_vec%0d", i), dc, tbl[i].cycles);
    end

    // Reset in the middle of a stalled lw read
    run_step(K_FETCH, 1'b1, 1'b0, 6'h00, 6'h00);
    run_step(K_DECODE, 1'b1, 1'b0, 6'h23, 6'h00);
    run_step(K_MEM_ADDR, 1'b1, 1'b0, 6'h23, 6'h00);
    run_step(K_MEM_READ, 1'b0, 1'b0, 6'h23, 6'h00);
    run_step(K_MEM_READ, 1'b0, 1'b0, 6'h23, 6'h00);
    do_reset(2);
    run_instr(6'h00, 6'h20, 1'b0, 0, 0, 0, dc, ml);
    check_int("latency_after_abort", dc, 4);

    // Every opcode through dispatch
    for (int unsigned op = 0; op < 64; op++) begin
      rfn = 6'($urandom);
      if (op == 0 && $urandom_range(0, 1) == 1) rfn = 6'h08;
      run_instr(6'(op), rfn, 1'($urandom_range(0, 1)), $urandom_range(0, 1),
                $urandom_range(0, 1), 3, dc, ml);
      check_int($sformatf("sweep_op%0d", op), dc, ml);
    end

    // Random legal instruction stream
    for (int unsigned n = 0; n < 60; n++) begin
      rop = legal_ops[$urandom_range(0, 5)];
      rfn = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
      run_instr(rop, rfn, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                $urandom_range(0, 3), 0, dc, ml);
      check_int($sformatf("rand_latency%0d", n), dc, ml);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
